// File: rtl/reduce_tree_pipe_pkg.sv
// Shared op codes and helpers for the pipelined bit-reduction tree.
package reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // NOR is reduced as OR inside the tree; inversion happens once at the output.
  function automatic logic op2(input logic [1:0] op, input logic a, input logic b);
    case (op_e'(op))
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

endpackage

// File: rtl/reduce_tree_pipe_if.sv
// Sample/result bus of the reduction tree.
// valid/ready: a beat moves on a rising edge where valid & ready are both high; the sender holds
// its payload stable while valid is high and ready is low; ready may depend combinationally on
// the far side's ready but valid never depends on ready.
interface reduce_tree_pipe_if #(
  parameter int N_IN = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   din;
  logic [1:0]        op;
  logic              out_valid;
  logic              out_ready;
  logic              y;
  logic [N_IN/2-1:0] part;
  logic [1:0]        op_out;

  modport master (
    output in_valid, din, op, out_ready,
    input  in_ready, out_valid, y, part, op_out
  );

  modport slave (
    input  in_valid, din, op, out_ready,
    output in_ready, out_valid, y, part, op_out
  );
endinterface

// File: rtl/reduce_tree_pipe_stage.sv
// One tree level: W bits reduced pairwise to W/2, optionally registered together with valid/op.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int W   = 4,
  parameter int REG = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           adv,
  input  logic           v_in,
  input  logic [1:0]     op_in,
  input  logic [W-1:0]   d_in,
  output logic           v_out,
  output logic [1:0]     op_out,
  output logic [W/2-1:0] d_out
);

  logic [W/2-1:0] pair;

  always_comb begin
    pair = '0;
    for (int i = 0; i < W/2; i++) begin
      pair[i] = op2(op_in, d_in[2*i], d_in[2*i+1]);
    end
  end

  if (REG != 0) begin : g_reg
    // Payload only loads with a valid sample, so bubbles never pull X into the tree.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_out  <= 1'b0;
        op_out <= '0;
        d_out  <= '0;
      end else if (adv) begin
        v_out <= v_in;
        if (v_in) begin
          op_out <= op_in;
          d_out  <= pair;
        end
      end
    end
  end else begin : g_comb
    assign v_out  = v_in;
    assign op_out = op_in;
    assign d_out  = pair;

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, adv};
  end

endmodule

// File: rtl/reduce_tree_pipe.sv
// N-input OR/AND/XOR/NOR reduction tree with global-stall flow control and a saturating
// count of delivered true results.
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int PIPE = 1,
  parameter int CW   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  reduce_tree_pipe_if.slave   bus,
  input  logic                cnt_clr,
  output logic [CW-1:0]       cnt_true
);

  localparam int LEVELS = clog2(N_IN);
  localparam int HALF   = N_IN / 2;
  localparam int NODES  = 2 * N_IN - 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic             adv;
  logic [NODES-1:0] node;   // level k occupies bits starting at 2*N_IN - 2*(N_IN>>k)
  logic [LEVELS:0]  lvl_v;
  logic [1:0]       lvl_op [LEVELS+1];
  logic             out_v;
  logic             y_raw;
  logic [1:0]       op_r;
  logic [HALF-1:0]  part_raw;
  logic             is_nor;

  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  assign node[N_IN-1:0] = bus.din;
  assign lvl_v[0]       = bus.in_valid;
  assign lvl_op[0]      = bus.op;

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int W  = N_IN >> k;
    localparam int OI = 2 * N_IN - 2 * W;
    localparam int OO = 2 * N_IN - W;
    reduce_stage #(.W(W), .REG(PIPE)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .v_in   (lvl_v[k]),
      .op_in  (lvl_op[k]),
      .d_in   (node[OI+W-1:OI]),
      .v_out  (lvl_v[k+1]),
      .op_out (lvl_op[k+1]),
      .d_out  (node[OO+W/2-1:OO])
    );
  end

  if (PIPE != 0) begin : g_pipe
    assign out_v = lvl_v[LEVELS];
    assign y_raw = node[NODES-1];
    assign op_r  = lvl_op[LEVELS];

    if (LEVELS == 1) begin : g_one
      assign part_raw = node[N_IN +: HALF];
    end else begin : g_align
      // Pair results ride a shift line so they leave together with their own y.
      logic [HALF-1:0] part_d [LEVELS-1];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LEVELS-1; i++) part_d[i] <= '0;
        end else if (adv) begin
          if (lvl_v[1]) part_d[0] <= node[N_IN +: HALF];
          for (int i = 1; i < LEVELS-1; i++) begin
            if (lvl_v[i+1]) part_d[i] <= part_d[i-1];
          end
        end
      end
      assign part_raw = part_d[LEVELS-2];
    end
  end else begin : g_flat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_v    <= 1'b0;
        y_raw    <= 1'b0;
        op_r     <= '0;
        part_raw <= '0;
      end else if (adv) begin
        out_v <= lvl_v[LEVELS];
        if (lvl_v[LEVELS]) begin
          y_raw    <= node[NODES-1];
          op_r     <= lvl_op[LEVELS];
          part_raw <= node[N_IN +: HALF];
        end
      end
    end
  end

  assign is_nor        = (op_r == OP_NOR);
  assign bus.out_valid = out_v;
  assign bus.y         = y_raw ^ is_nor;
  assign bus.part      = part_raw ^ {HALF{is_nor}};
  assign bus.op_out    = op_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_true <= '0;
    end else if (cnt_clr) begin
      cnt_true <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.y && cnt_true != CNT_MAX) begin
      cnt_true <= cnt_true + 1'b1;
    end
  end

endmodule
